// File: rtl/fetch_unit_64.sv
// rtl/fetch_unit_64.sv - multi-cycle byte-serial Y86-64 instruction fetch and decode
module fetch_unit_64 #(
  parameter logic [63:0] PC_RESET = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pc_load,
  input  logic [63:0] new_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_valid,
  input  logic        imem_err,
  output logic        busy,
  output logic        done,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        imem_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BYTE0 = 3'd1,
    S_REGS  = 3'd2,
    S_CONST = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [3:0]  idx;
  logic [3:0]  cur_icode, cur_ifun, cur_ra, cur_rb;
  logic [63:0] cur_valc;
  logic [3:0]  nx_icode, nx_ifun, nx_ra, nx_rb;
  logic [63:0] nx_valc;
  logic        ack;
  logic        entering_done;
  logic        next_fetching;
  logic [3:0]  const_off;
  logic [2:0]  const_k;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  assign ack = imem_req & (imem_valid | imem_err);

  // jXX/call carry the constant right after byte 0; the others after the register byte
  assign const_off = idx - (((cur_icode == 4'h7) || (cur_icode == 4'h8)) ? 4'd1 : 4'd2);
  assign const_k   = const_off[2:0];

  assign imem_addr = imem_req ? (pc + {60'd0, idx}) : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_BYTE0;
      S_BYTE0: begin
        if (ack) begin
          if (imem_err) next_state = S_DONE;
          else begin
            case (imem_rdata[7:4])
              4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: next_state = S_REGS;
              4'h7, 4'h8:                              next_state = S_CONST;
              default:                                 next_state = S_DONE;
            endcase
          end
        end
      end
      S_REGS: begin
        if (ack) begin
          if (imem_err || !((cur_icode == 4'h3) || (cur_icode == 4'h4) || (cur_icode == 4'h5)))
            next_state = S_DONE;
          else
            next_state = S_CONST;
        end
      end
      S_CONST: if (ack && (imem_err || (const_k == 3'd7))) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Working copy of the fields with the byte on the bus merged in
  always_comb begin
    nx_icode = cur_icode;
    nx_ifun  = cur_ifun;
    nx_ra    = cur_ra;
    nx_rb    = cur_rb;
    nx_valc  = cur_valc;
    case (state)
      S_BYTE0: begin
        nx_icode = imem_rdata[7:4];
        nx_ifun  = imem_rdata[3:0];
      end
      S_REGS: begin
        nx_ra = imem_rdata[7:4];
        nx_rb = imem_rdata[3:0];
      end
      S_CONST: nx_valc[{const_k, 3'b000} +: 8] = imem_rdata;
      default: ;
    endcase
  end

  assign entering_done = (state != S_DONE) && (next_state == S_DONE);
  assign next_fetching = (next_state == S_BYTE0) || (next_state == S_REGS) ||
                         (next_state == S_CONST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      idx         <= 4'd0;
      imem_req    <= 1'b0;
      cur_icode   <= 4'd0;
      cur_ifun    <= 4'd0;
      cur_ra      <= 4'd0;
      cur_rb      <= 4'd0;
      cur_valc    <= 64'd0;
      icode       <= 4'd0;
      ifun        <= 4'd0;
      rA          <= 4'd0;
      rB          <= 4'd0;
      valC        <= 64'd0;
      valP        <= 64'd0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
    end else begin
      imem_req <= next_fetching;
      if (state == S_IDLE) begin
        if (pc_load) pc <= new_pc;
        if (start) begin
          idx       <= 4'd0;
          cur_icode <= 4'd0;
          cur_ifun  <= 4'd0;
          cur_ra    <= 4'hF;
          cur_rb    <= 4'hF;
          cur_valc  <= 64'd0;
        end
      end else if (ack) begin
        idx       <= idx + 4'd1;
        cur_icode <= nx_icode;
        cur_ifun  <= nx_ifun;
        cur_ra    <= nx_ra;
        cur_rb    <= nx_rb;
        cur_valc  <= nx_valc;
      end
      if (entering_done) begin
        if (imem_err) begin
          // a faulted fetch reports a nop that does not advance the PC
          icode       <= 4'h1;
          ifun        <= 4'h0;
          rA          <= 4'hF;
          rB          <= 4'hF;
          valC        <= 64'd0;
          valP        <= pc;
          instr_valid <= 1'b0;
          imem_error  <= 1'b1;
        end else begin
          icode       <= nx_icode;
          ifun        <= nx_ifun;
          rA          <= nx_ra;
          rB          <= nx_rb;
          valC        <= nx_valc;
          valP        <= pc + {60'd0, instr_len(nx_icode)};
          instr_valid <= (nx_icode <= 4'd11);
          imem_error  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit_64.sv
// tb/tb_fetch_unit_64.sv - table-driven scoreboard bench for fetch_unit_64
module tb_fetch_unit_64;

  logic        clk = 1'b0;
  logic        reset, start, pc_load;
  logic [63:0] new_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_valid, imem_err;
  logic        busy, done;
  logic [63:0] pc;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_valid, imem_error;

  fetch_unit_64 dut (
    .clk(clk), .reset(reset), .start(start), .pc_load(pc_load), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .imem_err(imem_err), .busy(busy), .done(done),
    .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        load;
    logic [79:0] bytes;
    int          waits;
    int          err_b;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        iv, ierr;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t sb_q[$];
  vec_t vecs[11];

  logic [7:0]  mem [logic [63:0]];
  logic [63:0] base_pc = 64'd0;
  int ack_cnt = 0, wait_n = 0, wcnt = 0, err_b = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] p, input logic ld, input logic [79:0] b,
                              input int w, input int eb, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                              input logic [63:0] vp, input logic iv, input logic ie, input int lat);
    vec_t v;
    v.pc = p; v.load = ld; v.bytes = b; v.waits = w; v.err_b = eb;
    v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rb; v.valc = vc; v.valp = vp;
    v.iv = iv; v.ierr = ie; v.lat = lat;
    return v;
  endfunction

  // Memory model: acks after wait_n idle cycles, faults on byte err_b, checks addresses
  always @(negedge clk) begin
    imem_valid = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = 8'h00;
    if (imem_req) begin
      check("imem_addr", imem_addr, base_pc + 64'(ack_cnt));
      if (wcnt < wait_n) wcnt++;
      else begin
        wcnt = 0;
        if (ack_cnt == err_b) imem_err = 1'b1;
        else begin
          imem_valid = 1'b1;
          imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 8'h00;
        end
        ack_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) check("unexpected_done", {63'd0, done}, 64'd0);
      else begin
        vec_t e;
        e = sb_q.pop_front();
        check("pc", pc, e.pc);
        check("icode", {60'd0, icode}, {60'd0, e.icode});
        check("ifun", {60'd0, ifun}, {60'd0, e.ifun});
        check("rA", {60'd0, rA}, {60'd0, e.ra});
        check("rB", {60'd0, rB}, {60'd0, e.rb});
        check("valC", valC, e.valc);
        check("valP", valP, e.valp);
        check("instr_valid", {63'd0, instr_valid}, {63'd0, e.iv});
        check("imem_error", {63'd0, imem_error}, {63'd0, e.ierr});
      end
    end
  end

  task automatic load_mem(input logic [63:0] p, input logic [79:0] b, input int w, input int eb);
    mem.delete();
    for (int i = 0; i < 10; i++) mem[p + 64'(i)] = b[79 - 8*i -: 8];
    wait_n = w; err_b = eb; base_pc = p; ack_cnt = 0; wcnt = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic apply(input vec_t v);
    int lat;
    repeat (2) @(negedge clk);
    load_mem(v.pc, v.bytes, v.waits, v.err_b);
    start = 1'b1; pc_load = v.load; new_pc = v.pc;
    sb_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0; pc_load = 1'b0;
    wait_done(lat);
    check("latency", 64'(lat), 64'(v.lat));
  endtask

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; pc_load = 1'b0; new_pc = 64'd0;
    imem_valid = 1'b0; imem_err = 1'b0; imem_rdata = 8'h00;

    vecs[0]  = mk(64'h0, 1'b0, 80'h30F3_0807_0605_0403_0201, 0, -1, 4'h3, 4'h0, 4'hF, 4'h3,
                  64'h0102030405060708, 64'd10, 1'b1, 1'b0, 10);
    vecs[1]  = mk(64'h100, 1'b1, 80'h8000_0200_0000_0000_0000, 0, -1, 4'h8, 4'h0, 4'hF, 4'hF,
                  64'h200, 64'h109, 1'b1, 1'b0, 9);
    vecs[2]  = mk(64'h200, 1'b1, 80'h6023_0000_0000_0000_0000, 0, -1, 4'h6, 4'h0, 4'h2, 4'h3,
                  64'h0, 64'h202, 1'b1, 1'b0, 2);
    vecs[3]  = mk(64'h200, 1'b1, 80'h6023_0000_0000_0000_0000, 2, -1, 4'h6, 4'h0, 4'h2, 4'h3,
                  64'h0, 64'h202, 1'b1, 1'b0, 6);
    vecs[4]  = mk(64'h40, 1'b1, 80'hE000_0000_0000_0000_0000, 0, -1, 4'hE, 4'h0, 4'hF, 4'hF,
                  64'h0, 64'h41, 1'b0, 1'b0, 1);
    vecs[5]  = mk(64'h50, 1'b1, 80'h0000_0000_0000_0000_0000, 0, -1, 4'h0, 4'h0, 4'hF, 4'hF,
                  64'h0, 64'h51, 1'b1, 1'b0, 1);
    vecs[6]  = mk(64'h60, 1'b1, 80'h30F3_0807_0605_0403_0201, 0, 3, 4'h1, 4'h0, 4'hF, 4'hF,
                  64'h0, 64'h60, 1'b0, 1'b1, 4);
    vecs[7]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'h2545_0000_0000_0000_0000, 0, -1, 4'h2, 4'h5,
                  4'h4, 4'h5, 64'h0, 64'h1, 1'b1, 1'b0, 2);
    vecs[8]  = mk(64'h1000, 1'b1, 80'h730D_F0FE_CAEF_BEAD_DE00, 1, -1, 4'h7, 4'h3, 4'hF, 4'hF,
                  64'hDEAD_BEEF_CAFE_F00D, 64'h1009, 1'b1, 1'b0, 18);
    vecs[9]  = mk(64'h2000, 1'b1, 80'hA00F_0000_0000_0000_0000, 0, -1, 4'hA, 4'h0, 4'h0, 4'hF,
                  64'h0, 64'h2002, 1'b1, 1'b0, 2);
    vecs[10] = mk(64'h3000, 1'b1, 80'h5012_8877_6655_4433_2211, 0, -1, 4'h5, 4'h0, 4'h1, 4'h2,
                  64'h1122_3344_5566_7788, 64'h300A, 1'b1, 1'b0, 10);

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("rst_imem_req", {63'd0, imem_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_imem_error", {63'd0, imem_error}, 64'd0);
    check("rst_imem_addr", imem_addr, 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_fields", {48'd0, icode, ifun, rA, rB}, 64'd0);
    check("rst_valC", valC, 64'd0);
    check("rst_valP", valP, 64'd0);

    for (int i = 0; i < 11; i++) apply(vecs[i]);

    // pc_load and start while busy must both be ignored
    repeat (2) @(negedge clk);
    load_mem(64'h80, 80'h1000_0000_0000_0000_0000, 3, -1);
    start = 1'b1; pc_load = 1'b1; new_pc = 64'h80;
    sb_q.push_back(mk(64'h80, 1'b1, 80'h0, 3, -1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h81,
                      1'b1, 1'b0, 4));
    @(posedge clk); #1; start = 1'b0; pc_load = 1'b0;
    @(negedge clk); start = 1'b1; pc_load = 1'b1; new_pc = 64'hBAD;
    @(negedge clk); start = 1'b0; pc_load = 1'b0;
    wait_done(lat);
    check("busy_latency", 64'(lat), 64'd3);
    repeat (6) @(negedge clk);
    check("busy_pc_kept", pc, 64'h80);

    // reset during CONST aborts without done
    load_mem(64'h300, 80'h30F3_0807_0605_0403_0201, 0, -1);
    start = 1'b1; pc_load = 1'b1; new_pc = 64'h300;
    @(posedge clk); #1; start = 1'b0; pc_load = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("mid_busy", {63'd0, busy}, 64'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req", {63'd0, imem_req}, 64'd0);
    check("mid_rst_pc", pc, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_rst_idle_req", {63'd0, imem_req}, 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
